// File: rtl/lift_pkg.sv
// Shared types for the two-floor lift controller: state encoding, floor ids
// and the registered output bundle with its per-state decode.
package lift_pkg;

  typedef enum logic [2:0] {
    S_IDLE_G = 3'd0,
    S_DOOR_G = 3'd1,
    S_UP     = 3'd2,
    S_IDLE_T = 3'd3,
    S_DOOR_T = 3'd4,
    S_DN     = 3'd5
  } lift_state_e;

  localparam logic FLR_GND = 1'b0;
  localparam logic FLR_TOP = 1'b1;

  typedef struct packed {
    logic at_top;
    logic at_gnd;
    logic mv_up;
    logic mv_dn;
    logic door_open;
    logic clr_top;
    logic clr_gnd;
  } lift_out_t;

  // Output levels implied by a state; moving states belong to no floor.
  function automatic lift_out_t state_outputs(input lift_state_e s);
    lift_out_t o;
    logic      stopped;
    logic      flr;
    o           = '0;
    o.mv_up     = (s == S_UP);
    o.mv_dn     = (s == S_DN);
    o.door_open = (s == S_DOOR_G) || (s == S_DOOR_T);
    stopped     = !(o.mv_up || o.mv_dn);
    flr         = ((s == S_IDLE_T) || (s == S_DOOR_T)) ? FLR_TOP : FLR_GND;
    o.at_top    = stopped && (flr == FLR_TOP);
    o.at_gnd    = stopped && (flr == FLR_GND);
    o.clr_top   = o.door_open && (flr == FLR_TOP);
    o.clr_gnd   = o.door_open && (flr == FLR_GND);
    return o;
  endfunction

endpackage

// File: rtl/lift_tick_cnt.sv
// Tick-qualified loadable down counter; used as the door timer.
// done_c flags the last tick of a loaded period (count == 1).
module lift_tick_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         tick_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_c
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load has priority; otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (tick_i) begin
      if (load_i) begin
        cnt_d = value_i;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_c = (cnt_q == W'(1));

endmodule

// File: rtl/lift_ctrl.sv
// Two-floor lift car controller: serves ground/top requests, moves the car,
// times the door and clears the request latch of the floor being served.
// Optional feature macro: LIFT_DOOR_HOLD_EN adds a door_hold input that keeps
// an open door open and restarts the full door period on release.
module lift_ctrl
  import lift_pkg::*;
#(
  parameter int unsigned TRAVEL_TICKS = 8,
  parameter int unsigned DOOR_TICKS   = 4,
  parameter int unsigned PW           = 4
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          slowref,
  input  logic          req_top,
  input  logic          req_gnd,
`ifdef LIFT_DOOR_HOLD_EN
  input  logic          door_hold,
`endif
  output logic          clr_top,
  output logic          clr_gnd,
  output logic          at_top,
  output logic          at_gnd,
  output logic          mv_up,
  output logic          mv_dn,
  output logic          door_open,
  output logic [PW-1:0] pos
);

  localparam int unsigned CW = $clog2(DOOR_TICKS + 1);

  lift_state_e   state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  lift_out_t     out_q, out_d;
  logic          cnt_load;
  logic          door_done_c;
  logic          hold_c;

`ifdef LIFT_DOOR_HOLD_EN
  assign hold_c = door_hold;
`else
  assign hold_c = 1'b0;
`endif

  lift_tick_cnt #(
    .W (CW)
  ) u_door_tmr (
    .clk     (clk),
    .resetb  (resetb),
    .tick_i  (slowref),
    .load_i  (cnt_load),
    .value_i (CW'(DOOR_TICKS)),
    .done_c  (door_done_c)
  );

  // Next state, position and door-timer load; nothing moves without slowref.
  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    cnt_load = 1'b0;
    if (slowref) begin
      unique case (state_q)
        S_IDLE_G: begin
          if (req_gnd) begin
            state_d  = S_DOOR_G;
            cnt_load = 1'b1;
          end else if (req_top) begin
            state_d = S_UP;
          end
        end
        S_DOOR_G: begin
          if (hold_c) begin
            cnt_load = 1'b1;
          end else if (door_done_c) begin
            state_d = req_top ? S_UP : S_IDLE_G;
          end
        end
        S_UP: begin
          if (pos_q >= PW'(TRAVEL_TICKS - 1)) begin
            pos_d    = PW'(TRAVEL_TICKS);
            state_d  = S_DOOR_T;
            cnt_load = 1'b1;
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end
        S_IDLE_T: begin
          if (req_top) begin
            state_d  = S_DOOR_T;
            cnt_load = 1'b1;
          end else if (req_gnd) begin
            state_d = S_DN;
          end
        end
        S_DOOR_T: begin
          if (hold_c) begin
            cnt_load = 1'b1;
          end else if (door_done_c) begin
            state_d = req_gnd ? S_DN : S_IDLE_T;
          end
        end
        S_DN: begin
          if (pos_q <= PW'(1)) begin
            pos_d    = '0;
            state_d  = S_DOOR_G;
            cnt_load = 1'b1;
          end else begin
            pos_d = pos_q - PW'(1);
          end
        end
        default: begin
          state_d = S_IDLE_G;
          pos_d   = '0;
        end
      endcase
    end
    out_d = state_outputs(state_d);
  end

  // State, position and decoded outputs are all registered together.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE_G;
      pos_q   <= '0;
      out_q   <= state_outputs(S_IDLE_G);
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      out_q   <= out_d;
    end
  end

  assign clr_top   = out_q.clr_top;
  assign clr_gnd   = out_q.clr_gnd;
  assign at_top    = out_q.at_top;
  assign at_gnd    = out_q.at_gnd;
  assign mv_up     = out_q.mv_up;
  assign mv_dn     = out_q.mv_dn;
  assign door_open = out_q.door_open;
  assign pos       = pos_q;

endmodule
